// File: rtl/running_average.sv
// running_average: cumulative floor mean over the N packed lanes of a word, one lane per clock.
module running_average #(
  parameter int DATA_W = 8,
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W*N-1:0]   data_stream,
  output logic [DATA_W-1:0]     mean
);
  localparam int IW = $clog2(N);
  localparam int SW = DATA_W + IW;
  logic [IW-1:0]       idx;
  logic [DATA_W*N-1:0] frame_q;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       s;
  logic [SW-1:0]       divisor;
  logic [DATA_W-1:0]   lane;
  logic [IW-1:0]       idx_next;
  always_comb begin
    lane     = frame_q[idx*DATA_W +: DATA_W];
    s        = sum + SW'(lane);
    divisor  = SW'(idx) + SW'(1);
    idx_next = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
  end
  // The mean of k+1 samples never exceeds one sample's range, so the cast is lossless.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      sum     <= '0;
      frame_q <= '0;
      mean    <= '0;
    end else if (idx == '0) begin
      frame_q <= data_stream;
      sum     <= SW'(data_stream[DATA_W-1:0]);
      mean    <= data_stream[DATA_W-1:0];
      idx     <= idx_next;
    end else begin
      sum     <= s;
      mean    <= DATA_W'(s / divisor);
      idx     <= idx_next;
    end
  end
endmodule

// File: tb/tb_running_average.sv
// tb_running_average: random and directed stimulus checked against a frame-level mean model.
module tb_running_average;
  logic        clk;
  logic        rst;
  logic [63:0] data_stream;
  logic [7:0]  mean;
  int passed = 0;
  int total = 0;
  bit armed = 0;
  int m_idx;
  logic [63:0] m_frame;
  logic [7:0]  exp_mean;

  running_average #(.DATA_W(8), .N(8)) dut (
    .clk(clk),
    .rst(rst),
    .data_stream(data_stream),
    .mean(mean)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mean(input logic [63:0] w, input int k);
    int acc = 0;
    for (int i = 0; i <= k; i++) acc += int'(w[8*i +: 8]);
    return 8'(acc / (k + 1));
  endfunction

  // Reference: the mean of lanes 0..k of the word captured at frame start.
  always @(posedge clk) begin
    if (rst) begin
      m_idx    <= 0;
      m_frame  <= '0;
      exp_mean <= '0;
    end else if (m_idx == 0) begin
      m_frame  <= data_stream;
      exp_mean <= ref_mean(data_stream, 0);
      m_idx    <= 1;
    end else begin
      exp_mean <= ref_mean(m_frame, m_idx);
      m_idx    <= (m_idx + 1) % 8;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      total++;
      if (mean !== exp_mean)
        $display("FAIL model_cmp t=%0t: mean=%0d expected=%0d", $time, mean, exp_mean);
      else
        passed++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic lit(input logic [7:0] e, input string nm);
    total++;
    if (mean !== e)
      $display("FAIL %s: mean=%0d expected=%0d", nm, mean, e);
    else
      passed++;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  logic [7:0] vec_exp [9] = '{8'd5, 8'd65, 8'd78, 8'd120, 8'd97, 8'd102, 8'd102, 8'd104, 8'd5};
  logic [7:0] mid_exp [8] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4};
  logic [63:0] d2;

  initial begin
    rst = 1;
    data_stream = {$urandom, $urandom};
    tick();
    armed = 1;
    tick();
    lit(8'd0, "reset");
    rst = 0;
    data_stream = 64'h78677E05F8677E05;
    for (int i = 0; i < 9; i++) begin
      tick();
      lit(vec_exp[i], "vector");
    end
    do_reset();
    data_stream = '1;
    for (int i = 0; i < 8; i++) begin
      tick();
      lit(8'd255, "all_max");
    end
    do_reset();
    data_stream = 64'h0807060504030201;
    for (int i = 0; i < 8; i++) begin
      tick();
      lit(mid_exp[i], "mid_change");
      if (i == 2) data_stream = '1;
    end
    tick();
    lit(8'd255, "mid_next_frame");
    do_reset();
    data_stream = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) tick();
    rst = 1;
    tick();
    lit(8'd0, "reset_mid_frame");
    rst = 0;
    d2 = {$urandom, $urandom};
    data_stream = d2;
    tick();
    lit(d2[7:0], "restart_lane0");
    do_reset();
    data_stream = '0;
    for (int i = 0; i < 24; i++) begin
      tick();
      lit(8'd0, "zero");
    end
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      data_stream = {$urandom, $urandom};
      tick();
    end
    rst = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
